// File: rtl/pdh_cmd_dispatch.sv
// pdh_cmd_dispatch: PS->PL command dispatcher; optional ack timeout enabled by macro PDH_DISPATCH_TIMEOUT_EN
module pdh_cmd_dispatch #(
    parameter int NUM_MODULES    = 4,
    parameter int CMD_BITS       = 4,
    parameter int DATA_BITS      = 27,
    parameter int CB_BITS        = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst_ni,
    input  logic [31:0]                    gpio_i,
    output logic [31:0]                    gpio_o,
    output logic [NUM_MODULES-1:0]         mod_en_o,
    output logic [DATA_BITS-1:0]           mod_data_o,
    input  logic [NUM_MODULES-1:0]         mod_ack_i,
    input  logic [NUM_MODULES*CB_BITS-1:0] mod_cb_i,
    output logic                           busy_o
);
    localparam int TGT_W = NUM_MODULES > 1 ? $clog2(NUM_MODULES) : 1;
    localparam logic [CMD_BITS-1:0] STROBE = CMD_BITS'(14);
    localparam logic [CMD_BITS-1:0] IDLE   = '0;

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_WAIT} state_t;

    state_t               r_state;
    logic [31:0]          r_s1, r_s2;
    logic [CMD_BITS-1:0]  r_cmd_prev, r_pend_cmd, r_act_cmd, r_last_cmd;
    logic [DATA_BITS-1:0] r_pend_data;
    logic [TGT_W-1:0]     r_tgt;
    logic [CB_BITS-1:0]   r_cb;
    logic [7:0]           r_txn;
    logic                 r_err, r_tmo, r_ovr;

    logic [CMD_BITS-1:0]  w_cmd_s;
    logic [DATA_BITS-1:0] w_data_s;
    logic [TGT_W-1:0]     w_tgt;
    logic [CB_BITS-1:0]   w_cb;
    logic                 w_srst, w_strobe_edge, w_pend_ok, w_ack, w_tmo_hit;

    assign w_cmd_s       = r_s2[DATA_BITS +: CMD_BITS];
    assign w_data_s      = r_s2[DATA_BITS-1:0];
    assign w_srst        = r_s2[31];
    assign w_strobe_edge = (w_cmd_s == STROBE) && (r_cmd_prev != STROBE);
    assign w_pend_ok     = (r_pend_cmd != IDLE) && (int'(r_pend_cmd) <= NUM_MODULES);
    assign w_tgt         = TGT_W'(r_pend_cmd - CMD_BITS'(1));
    assign w_ack         = mod_ack_i[r_tgt];
    assign w_cb          = mod_cb_i[r_tgt*CB_BITS +: CB_BITS];

    assign gpio_o = {r_txn, 4'h0, r_ovr, r_tmo, busy_o, r_err, 4'(w_cmd_s), 4'(r_last_cmd), 8'(r_cb)};

    // two-flop synchroniser for the asynchronous PS GPIO word; soft reset travels through it
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= gpio_i;
            r_s2 <= r_s1;
        end
    end

`ifdef PDH_DISPATCH_TIMEOUT_EN
    localparam int TCW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TCW-1:0] r_tcnt;

    // counts cycles spent in WAIT_ACK; idles at zero elsewhere
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) r_tcnt <= '0;
        else r_tcnt <= (w_srst || r_state != S_WAIT || w_tmo_hit) ? '0 : r_tcnt + TCW'(1);
    end

    assign w_tmo_hit = (r_state == S_WAIT) && (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    // pending latch, strobe edge tracking and the dispatch FSM with registered outputs
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_cmd_prev  <= '0;
            r_pend_cmd  <= '0;
            r_pend_data <= '0;
            r_act_cmd   <= '0;
            r_last_cmd  <= '0;
            r_tgt       <= '0;
            r_cb        <= '0;
            r_txn       <= '0;
            r_err       <= 1'b0;
            r_tmo       <= 1'b0;
            r_ovr       <= 1'b0;
            mod_en_o    <= '0;
            mod_data_o  <= '0;
            busy_o      <= 1'b0;
        end else if (w_srst) begin
            r_state     <= S_IDLE;
            r_cmd_prev  <= '0;
            r_pend_cmd  <= '0;
            r_pend_data <= '0;
            r_act_cmd   <= '0;
            r_last_cmd  <= '0;
            r_tgt       <= '0;
            r_cb        <= '0;
            r_txn       <= '0;
            r_err       <= 1'b0;
            r_tmo       <= 1'b0;
            r_ovr       <= 1'b0;
            mod_en_o    <= '0;
            mod_data_o  <= '0;
            busy_o      <= 1'b0;
        end else begin
            r_cmd_prev <= w_cmd_s;
            mod_en_o   <= '0;
            if (w_cmd_s != IDLE && w_cmd_s != STROBE) begin
                r_pend_cmd  <= w_cmd_s;
                r_pend_data <= w_data_s;
            end
            if (w_strobe_edge && r_state != S_IDLE) r_ovr <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_strobe_edge && w_pend_ok) begin
                        r_state    <= S_DISPATCH;
                        mod_en_o   <= NUM_MODULES'(1) << w_tgt;
                        mod_data_o <= r_pend_data;
                        r_tgt      <= w_tgt;
                        r_act_cmd  <= r_pend_cmd;
                        busy_o     <= 1'b1;
                        r_err      <= 1'b0;
                        r_tmo      <= 1'b0;
                        r_ovr      <= 1'b0;
                    end else if (w_strobe_edge) begin
                        r_err      <= 1'b1;
                        r_last_cmd <= r_pend_cmd;
                    end
                end
                S_DISPATCH: r_state <= S_WAIT;
                S_WAIT: begin
                    if (w_ack) begin
                        r_state    <= S_IDLE;
                        r_cb       <= w_cb;
                        r_last_cmd <= r_act_cmd;
                        r_txn      <= r_txn + 8'd1;
                        busy_o     <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_state    <= S_IDLE;
                        r_tmo      <= 1'b1;
                        r_cb       <= '0;
                        r_last_cmd <= r_act_cmd;
                        busy_o     <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pdh_cmd_dispatch.sv
// tb_pdh_cmd_dispatch: table-driven and scoreboarded bench for pdh_cmd_dispatch
module tb_pdh_cmd_dispatch;
    localparam logic [3:0] STROBE = 4'hE;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] gpio_i = '0;
    logic [31:0] gpio_o;
    logic [3:0]  mod_en_o;
    logic [26:0] mod_data_o;
    logic [3:0]  mod_ack_i = '0;
    logic [31:0] mod_cb_i = '0;
    logic        busy_o;

    pdh_cmd_dispatch #(.NUM_MODULES(4), .CMD_BITS(4), .DATA_BITS(27), .CB_BITS(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_ni(rst_ni), .gpio_i(gpio_i), .gpio_o(gpio_o), .mod_en_o(mod_en_o),
        .mod_data_o(mod_data_o), .mod_ack_i(mod_ack_i), .mod_cb_i(mod_cb_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [26:0] data;
        int          dly;
        logic [7:0]  cb;
        logic [3:0]  exp_en;
    } vec_t;

    typedef struct {
        logic [3:0]  en;
        logic [26:0] data;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    vec_t        vt[7];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [3:0]  prev_en = '0;

    logic [7:0]  m_cb, m_last, m_txn;
    logic [26:0] m_data;
    logic        m_err, m_ovr, m_tmo;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // every enable pulse is matched against the scoreboard and must last one cycle
    always @(negedge clk) begin
        if (mod_en_o != 4'h0) begin
            chk("en_single_cycle", {28'h0, prev_en}, 32'h0);
            if (sbq.size() == 0) begin
                chk("en_unexpected", {28'h0, mod_en_o}, 32'h0);
            end else begin
                e = sbq.pop_front();
                chk("en_target", {28'h0, mod_en_o}, {28'h0, e.en});
                chk("en_data", {5'h0, mod_data_o}, {5'h0, e.data});
                chk("en_latency", cyc, e.cyc);
            end
        end
        prev_en = mod_en_o;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_word();
        return {m_txn, 4'h0, m_ovr, m_tmo, 1'b0, m_err, 4'h0, m_last[3:0], m_cb};
    endfunction

    task automatic model_reset();
        m_cb = '0; m_last = '0; m_txn = '0; m_data = '0;
        m_err = 1'b0; m_ovr = 1'b0; m_tmo = 1'b0;
    endtask

    task automatic start(input logic [3:0] c, input logic [26:0] d, input logic [3:0] en);
        gpio_i = {1'b0, c, d};
        step(4);
        gpio_i = {1'b0, STROBE, 27'h0};
        if (en != 4'h0) sbq.push_back('{en, d, cyc + 3});
        step(3);
        if (en != 4'h0) begin
            m_data = d; m_err = 1'b0; m_ovr = 1'b0; m_tmo = 1'b0;
        end
    endtask

    task automatic ack(input int idx, input logic [7:0] cb, input logic [3:0] c);
        mod_cb_i[idx*8 +: 8] = cb;
        mod_ack_i[idx] = 1'b1;
        step(1);
        mod_ack_i = '0;
        m_cb = cb; m_last = {4'h0, c}; m_txn = m_txn + 8'd1;
    endtask

    task automatic do_txn(input vec_t v);
        start(v.cmd, v.data, v.exp_en);
        if (v.exp_en != 4'h0) begin
            step(v.dly);
            chk("busy_before_ack", {31'h0, busy_o}, 32'h1);
            ack(int'(v.cmd) - 1, v.cb, v.cmd);
        end else begin
            m_err = 1'b1; m_last = {4'h0, v.cmd};
        end
        gpio_i = '0;
        step(3);
        chk("gpio_word", gpio_o, model_word());
        chk("data_hold", {5'h0, mod_data_o}, {5'h0, m_data});
    endtask

    initial begin
        vt[0] = '{4'h1, 27'h00000A5, 2, 8'h5A, 4'b0001};
        vt[1] = '{4'hD, 27'h0000000, 0, 8'h00, 4'b0000};
        vt[2] = '{4'h2, 27'h0012345, 1, 8'hC3, 4'b0010};
        vt[3] = '{4'h4, 27'h7FFFFFF, 5, 8'hFF, 4'b1000};
        vt[4] = '{4'h5, 27'h0000001, 0, 8'h00, 4'b0000};
        vt[5] = '{4'hF, 27'h0000002, 0, 8'h00, 4'b0000};
        vt[6] = '{4'h3, 27'h0ABCDEF, 3, 8'h81, 4'b0100};
        model_reset();
        step(2);
        rst_ni = 1'b1;
        step(1);
        chk("reset_gpio", gpio_o, 32'h0);
        chk("reset_en", {28'h0, mod_en_o}, 32'h0);
        chk("reset_data", {5'h0, mod_data_o}, 32'h0);
        chk("reset_busy", {31'h0, busy_o}, 32'h0);

        for (int i = 0; i < 7; i++) do_txn(vt[i]);

        // overrun: second strobe while waiting, then wrong-index ack, then real ack
        start(4'h3, 27'h0000333, 4'b0100);
        step(2);
        gpio_i = {1'b0, 4'h1, 27'h0000111};
        step(4);
        gpio_i = {1'b0, STROBE, 27'h0};
        step(4);
        chk("ovr_flag", {31'h0, gpio_o[19]}, 32'h1);
        chk("ovr_data_kept", {5'h0, mod_data_o}, 32'h333);
        mod_cb_i[7:0] = 8'hEE;
        mod_ack_i = 4'b0001;
        step(2);
        mod_ack_i = '0;
        chk("wrong_ack_ignored", {31'h0, busy_o}, 32'h1);
        ack(2, 8'h77, 4'h3);
        m_ovr = 1'b1;
        gpio_i = '0;
        step(3);
        chk("ovr_done_word", gpio_o, model_word());
        do_txn('{4'h2, 27'h0000042, 2, 8'h24, 4'b0010});

        // held strobe: one dispatch only
        start(4'h2, 27'h0000222, 4'b0010);
        step(2);
        ack(1, 8'h42, 4'h2);
        step(45);
        gpio_i = '0;
        step(3);
        chk("held_strobe_word", gpio_o, model_word());

        // asynchronous reset while waiting for ack
        start(4'h1, 27'h0000055, 4'b0001);
        step(1);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_gpio", gpio_o, 32'h0);
        chk("arst_busy", {31'h0, busy_o}, 32'h0);
        chk("arst_data", {5'h0, mod_data_o}, 32'h0);
        model_reset();
        gpio_i = '0;
        step(1);
        rst_ni = 1'b1;
        step(3);

        // soft reset through gpio_i[31] takes effect three clocks later
        start(4'h2, 27'h0000066, 4'b0010);
        step(2);
        gpio_i = 32'h8000_0000;
        step(2);
        chk("srst_not_yet", {31'h0, busy_o}, 32'h1);
        step(1);
        chk("srst_gpio", gpio_o, 32'h0);
        chk("srst_busy", {31'h0, busy_o}, 32'h0);
        chk("srst_data", {5'h0, mod_data_o}, 32'h0);
        model_reset();
        gpio_i = '0;
        step(3);

`ifdef PDH_DISPATCH_TIMEOUT_EN
        start(4'h4, 27'h0000044, 4'b1000);
        step(10);
        chk("tmo_still_busy", {31'h0, busy_o}, 32'h1);
        step(10);
        chk("tmo_idle", {31'h0, busy_o}, 32'h0);
        m_tmo = 1'b1; m_cb = '0; m_last = 8'h4;
        gpio_i = '0;
        step(3);
        chk("tmo_word", gpio_o, model_word());
`endif

        // txn_cnt wraps after 256 acked transactions
        for (int i = 0; i < 256; i++)
            do_txn('{4'((i % 4) + 1), 27'(i), 1 + (i % 3), 8'(i * 7), 4'b0001 << (i % 4)});
        chk("txn_wrap", {24'h0, gpio_o[31:24]}, 32'h0);
        chk("sb_drain", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
